agu_seq: RTL
============

# agu_seq

Job sequencer directly upstream of the address generation unit (AGU). It accepts a job of `total` addresses and drives the AGU's `clr`/`step` inputs. For every address it issues one memory read strobe, and it re-times the strobe through a read-latency pipe so the consumer sees a data-valid/last marker aligned with returning memory data. It reports job completion with `busy`/`done`; the memory address bus is driven directly by the AGU's `addr_out`.

## Interface
- `BWCOUNT`, 24, width of the job length / remaining-address counter
- `RDLAT`, 2, memory read latency in cycles (legal range ≥ 1)

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  job request; sampled only in IDLE
- `total`  in  BWCOUNT  number of addresses in the job; sampled with `start`
- `stall`  in  1  downstream hold; blocks read issue and AGU advance in RUN
- `busy`  out  1  job in progress
- `done`  out  1  one-cycle completion pulse
- `agu_clr`  out  1  to AGU `clr`
- `agu_step`  out  1  to AGU `step`
- `rd_en`  out  1  memory read strobe; the address is AGU `addr_out` in the same cycle
- `rd_valid`  out  1  `rd_en` delayed by exactly RDLAT cycles
- `rd_last`  out  1  marks the final `rd_valid` of the job

## Operation
- States: IDLE, CLR, RUN, DRAIN. Remaining counter `rem` is BWCOUNT bits.
- IDLE:
  - `start`=1 and `total`≠0: `rem`←`total`, go to CLR.
  - `start`=1 and `total`=0: `done` pulses next cycle, state stays IDLE, `busy` and `agu_*` stay 0.
- CLR (exactly one cycle):
  - `agu_clr`=1, `agu_step`=1, so the AGU address is 0 in the next cycle.
  - `stall` is ignored. Go to RUN.
- RUN:
  - `stall`=1: `rd_en`=0, `agu_step`=0, `rem` held.
  - `stall`=0: `rd_en`=1 and `rem`←`rem`−1. `agu_step`=1 only when `rem`>1, so the AGU holds its last address after the final read.
  - When `rem`=1 and `stall`=0, this is the final issue: go to DRAIN.
- DRAIN:
  - No issue, and `stall` is ignored.
  - When `rd_last` is high, go to IDLE. In the following cycle `done`=1 and `busy`=0.
- Valid pipe:
  - RDLAT-deep shift register of {`rd_en`, final-issue flag}.
  - Outputs `rd_valid` and `rd_last` (`rd_last` ⇒ `rd_valid`).
- `start` while not in IDLE is ignored (no queueing). `start` in the cycle where `done`=1 is accepted, because the state is already IDLE.
- `agu_clr` is only ever asserted together with `agu_step`, since the AGU ignores `clr` without `step`.
- No arithmetic wrap: `rem` never decrements below 1 inside RUN.

## Timing
- Reset values: state IDLE, `rem`=0, valid pipe cleared. `busy`, `done`, `agu_clr`, `agu_step`, `rd_en`, `rd_valid`, `rd_last` are all 0.
- `busy` and `done` are registered.
- `agu_clr`, `agu_step` and `rd_en` are decoded from state, `rem` and `stall` (combinational from registers and `stall`).
- Cycle numbering, start accepted at cycle 0, no stalls, N=`total`, L=RDLAT:
  - `busy` rises at cycle 1.
  - CLR at cycle 1.
  - `rd_en` in cycles 2..N+1.
  - `agu_step` in cycles 1..N.
  - `rd_valid` in cycles 2+L..N+1+L.
  - `rd_last` at cycle N+1+L.
  - `done` at cycle N+2+L, with `busy` falling in the same cycle.
- Each stalled RUN cycle delays all subsequent events by one cycle.
- `rst` mid-job: takes effect on the next edge and aborts the job.
  - All outputs are 0 from the following cycle.
  - In-flight `rd_valid` bits are discarded.
  - No `done` pulse.
  - The AGU is not cleared by `rst`; the next job's CLR cycle re-initialises it.
- Throughput: one address per cycle in RUN. Job-to-job overhead is L+2 cycles.

## Test plan
- Reset, then `start`, `total`=4, RDLAT=2, no stall → `agu_clr` at cycle 1 only; `agu_step` cycles 1–4; `rd_en` cycles 2–5; AGU address 0 at cycle 2; `rd_valid` cycles 4–7; `rd_last` at 7; `done` at 8; `busy` cycles 1–7.
- `total`=3, `stall`=1 in cycles 3–4 → `rd_en` at cycles 2, 5, 6; `agu_step` at cycles 1, 2, 5; `rd_last` at 8; `done` at 9.
- `total`=0 → `done` at cycle 1; `busy`, `agu_clr`, `agu_step`, `rd_en` never assert.
- `total`=1 → one `rd_en` at cycle 2 with `agu_step`=0; `rd_last` at 4; `done` at 5.
- `start` pulsed at cycle 3 of a `total`=4 job → ignored. `start` in the `done` cycle with `total`=2 → CLR on the next cycle.
- `rst` asserted at cycle 3 of a `total`=4 job → from cycle 4 all outputs are 0 and no `rd_valid`/`done` appears. A new job afterwards completes normally with the AGU restarting at address 0.

Source files
------------

// File: rtl/agu_seq.sv
// Job sequencer in front of the address generation unit: clears/steps the AGU,
// issues one read strobe per address and re-times it to the returning read data.
//   state | meaning
//   IDLE  | waiting for start
//   CLR   | one cycle, AGU cleared to address 0
//   RUN   | one read per unstalled cycle
//   DRAIN | waiting for the last read to leave the latency pipe
module agu_seq #(
  parameter int BWCOUNT = 24,
  parameter int RDLAT   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BWCOUNT-1:0] total,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic               agu_clr,
  output logic               agu_step,
  output logic               rd_en,
  output logic               rd_valid,
  output logic               rd_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [BWCOUNT-1:0] rem;
  logic [BWCOUNT-1:0] rem_nx;
  logic [RDLAT-1:0]   v_pipe;
  logic [RDLAT-1:0]   l_pipe;
  logic               final_issue;
  logic               done_nx;

  always_comb begin
    state_nx    = state;
    rem_nx      = rem;
    agu_clr     = 1'b0;
    agu_step    = 1'b0;
    rd_en       = 1'b0;
    final_issue = 1'b0;
    done_nx     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (total != '0) begin
            rem_nx   = total;
            state_nx = S_CLR;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      S_CLR: begin
        agu_clr  = 1'b1;
        agu_step = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: begin
        if (!stall) begin
          rd_en  = 1'b1;
          rem_nx = rem - BWCOUNT'(1);
          // the AGU keeps its last address once the final read is issued
          if (rem > BWCOUNT'(1)) begin
            agu_step = 1'b1;
          end else begin
            final_issue = 1'b1;
            state_nx    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (rd_last) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      rem    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      v_pipe <= '0;
      l_pipe <= '0;
    end else begin
      state  <= state_nx;
      rem    <= rem_nx;
      busy   <= (state_nx != S_IDLE);
      done   <= done_nx;
      v_pipe <= (v_pipe << 1) | RDLAT'(rd_en);
      l_pipe <= (l_pipe << 1) | RDLAT'(final_issue);
    end
  end

  assign rd_valid = v_pipe[RDLAT-1];
  assign rd_last  = l_pipe[RDLAT-1];

endmodule
